// File: rtl/calc_sequencer.sv
// calc_sequencer
//   Keypad-driven operand/operation sequencer for a 4-function calculator.
//   It accepts one key code per handshake and latches operand A, the
//   operation and operand B. On equals it spends one EXEC cycle forming an
//   8-bit result. Add, sub and mul are computed here. Divide uses the
//   quotient and remainder from an external combinational divider. A
//   sticky divide-by-zero error flag is kept. A new operation can be
//   chained onto the previous result.
//
// Ports
//   clk, rst_n         clock, asynchronous active-low reset
//   key_valid/ready    key handshake; a key is accepted on valid && ready
//   key_code[4:0]      key code:
//                        00-0F digit, 10 add, 11 sub, 12 mul, 13 div,
//                        14 equals, 15 clear, 16-1F ignored (consumed)
//   div_a, div_b       dividend/divisor to the divider (registers a/b)
//   div_q, div_r       quotient/remainder from the divider
//   res[7:0]           registered result
//   res_valid          one-cycle pulse when res/err update
//   err                sticky divide-by-zero flag
//   busy               high while in EXEC
module calc_sequencer (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       key_valid,
   input  logic [4:0] key_code,
   output logic       key_ready,
   output logic [3:0] div_a,
   output logic [3:0] div_b,
   input  logic [3:0] div_q,
   input  logic [3:0] div_r,
   output logic [7:0] res,
   output logic       res_valid,
   output logic       err,
   output logic       busy
);

   typedef enum logic [2:0] {S_A, S_OP, S_B, EXEC, DONE} state_t;

   state_t     state, state_nx;
   logic [3:0] a_q, a_nx, b_q, b_nx;
   logic [1:0] op_q, op_nx;
   logic       b_loaded_q, b_loaded_nx;
   logic [7:0] res_q, res_nx;
   logic       err_q, err_nx;
   logic       res_valid_q, res_valid_nx;

   logic       accept, is_digit, is_op, is_eq, is_clr;
   logic [4:0] sum;
   logic [7:0] diff, prod;

   assign accept   = key_valid && (state != EXEC);
   assign is_digit = ~key_code[4];
   assign is_op    = (key_code[4:2] == 3'b100);
   assign is_eq    = (key_code == 5'h14);
   assign is_clr   = (key_code == 5'h15);

   assign sum  = {1'b0, a_q} + {1'b0, b_q};
   assign diff = {4'b0000, a_q} - {4'b0000, b_q};
   assign prod = {4'b0000, a_q} * {4'b0000, b_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_A;
         a_q         <= '0;
         b_q         <= '0;
         op_q        <= '0;
         b_loaded_q  <= 1'b0;
         res_q       <= '0;
         err_q       <= 1'b0;
         res_valid_q <= 1'b0;
      end else begin
         state       <= state_nx;
         a_q         <= a_nx;
         b_q         <= b_nx;
         op_q        <= op_nx;
         b_loaded_q  <= b_loaded_nx;
         res_q       <= res_nx;
         err_q       <= err_nx;
         res_valid_q <= res_valid_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      a_nx         = a_q;
      b_nx         = b_q;
      op_nx        = op_q;
      b_loaded_nx  = b_loaded_q;
      res_nx       = res_q;
      err_nx       = err_q;
      res_valid_nx = 1'b0;

      case (state)
         S_A: begin
            if (accept && is_digit) begin
               a_nx     = key_code[3:0];
               state_nx = S_OP;
            end
         end
         S_OP: begin
            if (accept && is_digit) begin
               a_nx = key_code[3:0];
            end else if (accept && is_op) begin
               op_nx       = key_code[1:0];
               b_loaded_nx = 1'b0;
               state_nx    = S_B;
            end
         end
         S_B: begin
            if (accept && is_digit) begin
               b_nx        = key_code[3:0];
               b_loaded_nx = 1'b1;
            end else if (accept && is_op) begin
               op_nx = key_code[1:0];
            end else if (accept && is_eq && b_loaded_q) begin
               state_nx = EXEC;
            end
         end
         EXEC: begin
            res_valid_nx = 1'b1;
            err_nx       = 1'b0;
            state_nx     = DONE;
            case (op_q)
               2'b00: res_nx = {3'b000, sum};
               2'b01: res_nx = diff;
               2'b10: res_nx = prod;
               default: begin
                  if (b_q == 4'h0) begin
                     res_nx = '0;
                     err_nx = 1'b1;
                  end else begin
                     res_nx = {div_r, div_q};
                  end
               end
            endcase
         end
         DONE: begin
            if (accept && is_digit) begin
               a_nx     = key_code[3:0];
               err_nx   = 1'b0;
               state_nx = S_OP;
            end else if (accept && is_op && !err_q) begin
               // Chain: the low nibble of the previous result becomes A.
               a_nx        = res_q[3:0];
               op_nx       = key_code[1:0];
               b_loaded_nx = 1'b0;
               state_nx    = S_B;
            end
         end
         default: state_nx = S_A;
      endcase

      // Clear overrides every per-state action; accept is never set in EXEC.
      if (accept && is_clr) begin
         a_nx        = '0;
         b_nx        = '0;
         op_nx       = '0;
         b_loaded_nx = 1'b0;
         res_nx      = '0;
         err_nx      = 1'b0;
         state_nx    = S_A;
      end
   end

   assign key_ready = (state != EXEC);
   assign busy      = (state == EXEC);
   assign div_a     = a_q;
   assign div_b     = b_q;
   assign res       = res_q;
   assign err       = err_q;
   assign res_valid = res_valid_q;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer
//   Directed bench for calc_sequencer. A behavioural divider drives
//   div_q/div_r. It returns all-ones on a zero divisor, so a result taken
//   from the divider in that case is visible. Each task drives keys and
//   compares outputs against hand-computed values. Outputs are sampled 1
//   time unit after the rising edge.
module tb_calc_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [4:0] key_code = '0;
   logic       key_ready;
   logic [3:0] div_a, div_b, div_q, div_r;
   logic [7:0] res;
   logic       res_valid, err, busy;

   int unsigned errors = 0;
   int unsigned checks = 0;

   localparam logic [4:0] K_ADD = 5'h10, K_SUB = 5'h11, K_MUL = 5'h12,
                          K_DIV = 5'h13, K_EQ = 5'h14, K_CLR = 5'h15;

   always #5 clk = ~clk;

   assign div_q = (div_b == 4'h0) ? 4'hF : div_a / div_b;
   assign div_r = (div_b == 4'h0) ? 4'hF : div_a % div_b;

   calc_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_code  (key_code),
      .key_ready (key_ready),
      .div_a     (div_a),
      .div_b     (div_b),
      .div_q     (div_q),
      .div_r     (div_r),
      .res       (res),
      .res_valid (res_valid),
      .err       (err),
      .busy      (busy)
   );

   // Present one key, wait (bounded) for key_ready, and return 1 unit
   // after the accepting edge with key_valid dropped.
   task automatic press(input logic [4:0] c);
      int unsigned n;
      n = 0;
      key_valid = 1'b1;
      key_code  = c;
      while (!key_ready && n < 8) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!key_ready) begin
         errors++;
         $display("FAIL press_timeout key=%h key_ready=%b required 1", c, key_ready);
      end
      @(posedge clk); #1;
      key_valid = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      #12;
      checks++; if (res !== 8'h00)   begin errors++; $display("FAIL reset_res got %h exp 00", res); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid got %b exp 0", res_valid); end
      checks++; if (err !== 1'b0)    begin errors++; $display("FAIL reset_err got %b exp 0", err); end
      checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b exp 1", key_ready); end
      checks++; if ({div_a, div_b} !== 8'h00) begin errors++; $display("FAIL reset_ab got %h exp 00", {div_a, div_b}); end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_add;
      press(5'h07); press(K_ADD); press(5'h09); press(K_EQ);
      checks++; if (busy !== 1'b1)      begin errors++; $display("FAIL add_busy got %b exp 1", busy); end
      checks++; if (key_ready !== 1'b0) begin errors++; $display("FAIL add_key_ready got %b exp 0", key_ready); end
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_rv_early got %b exp 0", res_valid); end
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL add_rv got %b exp 1", res_valid); end
      checks++; if (res !== 8'h10)      begin errors++; $display("FAIL add_res got %h exp 10", res); end
      checks++; if (err !== 1'b0)       begin errors++; $display("FAIL add_err got %b exp 0", err); end
      checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL add_busy_done got %b exp 0", busy); end
      @(posedge clk); #1;
      checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL add_rv_pulse got %b exp 0", res_valid); end
      checks++; if (res !== 8'h10)      begin errors++; $display("FAIL add_res_hold got %h exp 10", res); end
   endtask

   task automatic test_div;
      press(5'h0D); press(K_DIV); press(5'h03); press(K_EQ);
      checks++; if (div_a !== 4'hD) begin errors++; $display("FAIL div_a got %h exp d", div_a); end
      checks++; if (div_b !== 4'h3) begin errors++; $display("FAIL div_b got %h exp 3", div_b); end
      @(posedge clk); #1;
      checks++; if (res !== 8'h14) begin errors++; $display("FAIL div_res got %h exp 14", res); end
      checks++; if (err !== 1'b0)  begin errors++; $display("FAIL div_err got %b exp 0", err); end
   endtask

   task automatic test_div_zero;
      press(5'h05); press(K_DIV); press(5'h00); press(K_EQ);
      @(posedge clk); #1;
      checks++; if (res !== 8'h00) begin errors++; $display("FAIL dz_res got %h exp 00", res); end
      checks++; if (err !== 1'b1)  begin errors++; $display("FAIL dz_err got %b exp 1", err); end
      press(K_ADD);
      checks++; if (err !== 1'b1)   begin errors++; $display("FAIL dz_op_err got %b exp 1", err); end
      checks++; if (div_a !== 4'h5) begin errors++; $display("FAIL dz_op_ignored_a got %h exp 5", div_a); end
      press(5'h02);
      checks++; if (err !== 1'b0)   begin errors++; $display("FAIL dz_digit_err got %b exp 0", err); end
      checks++; if (div_a !== 4'h2) begin errors++; $display("FAIL dz_digit_a got %h exp 2", div_a); end
      press(K_EQ);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_eq_in_op got busy %b exp 0", busy); end
   endtask

   task automatic test_chain;
      press(K_CLR);
      checks++; if ({div_a, div_b, res} !== 16'h0000) begin errors++; $display("FAIL chain_clear got %h exp 0000", {div_a, div_b, res}); end
      press(5'h03); press(K_SUB); press(5'h05); press(K_EQ);
      @(posedge clk); #1;
      checks++; if (res !== 8'hFE) begin errors++; $display("FAIL chain_sub got %h exp fe", res); end
      press(K_MUL);
      checks++; if (div_a !== 4'hE) begin errors++; $display("FAIL chain_a got %h exp e", div_a); end
      checks++; if (div_b !== 4'h5) begin errors++; $display("FAIL chain_b_kept got %h exp 5", div_b); end
      press(K_EQ);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL chain_eq_unloaded got busy %b exp 0", busy); end
      press(5'h02); press(K_EQ);
      @(posedge clk); #1;
      checks++; if (res !== 8'h1C) begin errors++; $display("FAIL chain_mul got %h exp 1c", res); end
   endtask

   task automatic test_hold_equals;
      int unsigned nbusy, nrv;
      nbusy = 0; nrv = 0;
      press(5'h04); press(K_ADD); press(5'h01);
      key_valid = 1'b1; key_code = K_EQ;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (busy === 1'b1) nbusy++;
         if (res_valid === 1'b1) nrv++;
      end
      key_valid = 1'b0;
      checks++; if (nbusy !== 1) begin errors++; $display("FAIL hold_busy_cycles got %0d exp 1", nbusy); end
      checks++; if (nrv !== 1)   begin errors++; $display("FAIL hold_rv_pulses got %0d exp 1", nrv); end
      checks++; if (res !== 8'h05) begin errors++; $display("FAIL hold_res got %h exp 05", res); end
   endtask

   task automatic test_clear_in_b;
      press(5'h06); press(K_MUL); press(5'h02); press(K_CLR);
      checks++; if ({div_a, div_b} !== 8'h00) begin errors++; $display("FAIL clr_ab got %h exp 00", {div_a, div_b}); end
      checks++; if (res !== 8'h00) begin errors++; $display("FAIL clr_res got %h exp 00", res); end
      checks++; if (err !== 1'b0)  begin errors++; $display("FAIL clr_err got %b exp 0", err); end
      press(K_EQ);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL clr_eq_in_a got busy %b exp 0", busy); end
      press(5'h06); press(K_ADD); press(K_EQ);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b_eq_no_digit got busy %b exp 0", busy); end
      press(5'h1A);
      checks++; if ({div_a, div_b} !== 8'h60) begin errors++; $display("FAIL ignored_key got %h exp 60", {div_a, div_b}); end
      press(5'h01); press(K_SUB); press(K_EQ);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL op_overwrite_exec got busy %b exp 1", busy); end
      @(posedge clk); #1;
      checks++; if (res !== 8'h05) begin errors++; $display("FAIL op_overwrite_res got %h exp 05", res); end
   endtask

   task automatic test_boundary;
      press(5'h0F); press(K_MUL); press(5'h0F); press(K_EQ);
      @(posedge clk); #1;
      checks++; if (res !== 8'hE1) begin errors++; $display("FAIL mul_max got %h exp e1", res); end
      press(5'h0F); press(K_ADD); press(5'h0F); press(K_EQ);
      @(posedge clk); #1;
      checks++; if (res !== 8'h1E) begin errors++; $display("FAIL add_max got %h exp 1e", res); end
      press(5'h00); press(K_SUB); press(5'h0F); press(K_EQ);
      @(posedge clk); #1;
      checks++; if (res !== 8'hF1) begin errors++; $display("FAIL sub_min got %h exp f1", res); end
      press(5'h0F); press(K_DIV); press(5'h01); press(K_EQ);
      @(posedge clk); #1;
      checks++; if (res !== 8'h0F) begin errors++; $display("FAIL div_by_one got %h exp 0f", res); end
   endtask

   task automatic test_reset_exec;
      int unsigned nrv;
      nrv = 0;
      press(5'h02); press(K_ADD); press(5'h03); press(K_EQ);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_exec_entry got busy %b exp 1", busy); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (res !== 8'h00)      begin errors++; $display("FAIL rst_exec_res got %h exp 00", res); end
      checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_ready got %b exp 1", key_ready); end
      #3 rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         if (res_valid === 1'b1) nrv++;
      end
      checks++; if (nrv !== 0) begin errors++; $display("FAIL rst_exec_rv got %0d pulses exp 0", nrv); end
      checks++; if (res !== 8'h00) begin errors++; $display("FAIL rst_exec_res_after got %h exp 00", res); end
      checks++; if (key_ready !== 1'b1) begin errors++; $display("FAIL rst_exec_ready_after got %b exp 1", key_ready); end
   endtask

   initial begin
      test_reset;
      test_add;
      test_div;
      test_div_zero;
      test_chain;
      test_hold_equals;
      test_clear_in_b;
      test_boundary;
      test_reset_exec;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
